wormhole_port_alloc: RTL and testbench

WORMHOLE_PORT_ALLOC -- requirements
Module: wormhole_port_alloc

---
 rtl/wormhole_port_alloc.sv | 168 ++++++++++++++++
 tb/tb_wormhole_port_alloc.sv | 128 ++++++++++++
 2 files changed

// File: rtl/wormhole_port_alloc.sv
// rtl/wormhole_port_alloc.sv - wormhole output-port allocator with matrix arbitration and credit flow control
module wormhole_port_alloc #(
    parameter int IN_N    = 5,
    parameter int CREDITS = 4,
    localparam int SW     = (IN_N > 1) ? $clog2(IN_N) : 1,
    localparam int CW     = $clog2(CREDITS + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [IN_N-1:0] req_i,
    input  logic [IN_N-1:0] tail_i,
    input  logic            credit_i,
    output logic [IN_N-1:0] ack_o,
    output logic [SW-1:0]   sel_o,
    output logic            fwd_o,
    output logic            busy_o,
    output logic [CW-1:0]   credits_o,
    output logic            err_o
);

    // Only pairs (i, j) with i < j are stored; bit set means i beats j.
    localparam int NPAIR = (IN_N * (IN_N - 1)) / 2;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     owner_q, owner_d;
    logic [NPAIR-1:0]  prio_q, prio_d;
    logic [CW-1:0]     credits_q;
    logic              err_q;

    logic [IN_N*IN_N-1:0] beats;      // beats[i*IN_N+j]: input i beats input j
    logic [IN_N-1:0]      win;
    logic [SW-1:0]        win_idx;
    logic                 has_credit;
    logic                 xfer;
    logic                 tail_xfer;

    function automatic int pidx(input int i, input int j);
        return i * IN_N - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    // Expand the stored upper triangle into the full antisymmetric matrix.
    for (genvar gi = 0; gi < IN_N; gi++) begin : g_row
        for (genvar gj = 0; gj < IN_N; gj++) begin : g_col
            if (gi < gj) begin : g_upper
                assign beats[gi*IN_N+gj] = prio_q[pidx(gi, gj)];
            end else if (gi > gj) begin : g_lower
                assign beats[gi*IN_N+gj] = ~prio_q[pidx(gj, gi)];
            end else begin : g_diag
                assign beats[gi*IN_N+gj] = 1'b0;
            end
        end
    end

    // A requester wins when no other requester beats it.
    always_comb begin
        win = '0;
        for (int i = 0; i < IN_N; i++) begin
            logic blocked;
            blocked = 1'b0;
            for (int j = 0; j < IN_N; j++) begin
                if (j != i && req_i[j] && beats[j*IN_N+i]) begin
                    blocked = 1'b1;
                end
            end
            win[i] = req_i[i] & ~blocked;
        end
    end

    // Encode the one-hot winner; zero when nobody requests.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < IN_N; i++) begin
            if (win[i]) begin
                win_idx = SW'(i);
            end
        end
    end

    assign has_credit = (credits_q != '0);

    // Next-state, grant and mux-select decode.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ack_o     = '0;
        sel_o     = '0;
        tail_xfer = 1'b0;
        case (state_q)
            IDLE: begin
                sel_o = win_idx;
                if (!rst_i && (|req_i) && has_credit) begin
                    ack_o = win;
                    if (|(win & tail_i)) begin
                        tail_xfer = 1'b1;
                    end else begin
                        state_d = LOCKED;
                        owner_d = win_idx;
                    end
                end
            end
            LOCKED: begin
                sel_o = owner_q;
                if (!rst_i && req_i[owner_q] && has_credit) begin
                    ack_o[owner_q] = 1'b1;
                    if (tail_i[owner_q]) begin
                        tail_xfer = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign xfer = |ack_o;

    // On a tail transfer the sender (sel_o) drops below every other input.
    for (genvar gi = 0; gi < IN_N; gi++) begin : g_prow
        for (genvar gj = gi + 1; gj < IN_N; gj++) begin : g_pcol
            assign prio_d[pidx(gi, gj)] =
                (tail_xfer && sel_o == SW'(gi)) ? 1'b0 :
                (tail_xfer && sel_o == SW'(gj)) ? 1'b1 :
                prio_q[pidx(gi, gj)];
        end
    end

    // State, owner and priority registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            prio_q  <= '1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
        end
    end

    // Downstream credit counter with sticky overflow flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credits_q <= CW'(CREDITS);
            err_q     <= 1'b0;
        end else if (xfer && !credit_i) begin
            credits_q <= credits_q - 1'b1;
        end else if (credit_i && !xfer) begin
            if (credits_q == CW'(CREDITS)) begin
                err_q <= 1'b1;
            end else begin
                credits_q <= credits_q + 1'b1;
            end
        end
    end

    assign fwd_o     = xfer;
    assign busy_o    = (state_q == LOCKED);
    assign credits_o = credits_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_wormhole_port_alloc.sv
// tb/tb_wormhole_port_alloc.sv - directed vector bench for wormhole_port_alloc
module tb_wormhole_port_alloc;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] req_i;
    logic [4:0] tail_i;
    logic       credit_i;
    logic [4:0] ack_o;
    logic [2:0] sel_o;
    logic       fwd_o;
    logic       busy_o;
    logic [2:0] credits_o;
    logic       err_o;

    int n_cmp = 0;
    int n_bad = 0;

    wormhole_port_alloc #(.IN_N(5), .CREDITS(4)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .tail_i    (tail_i),
        .credit_i  (credit_i),
        .ack_o     (ack_o),
        .sel_o     (sel_o),
        .fwd_o     (fwd_o),
        .busy_o    (busy_o),
        .credits_o (credits_o),
        .err_o     (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string      name;
        logic       rst;
        logic [4:0] req;
        logic [4:0] tail;
        logic       cr;
        logic [4:0] ack;
        logic [2:0] sel;
        logic       busy;
        logic [2:0] cred;
        logic       err;
    } vec_t;

    vec_t vecs[27];

    task automatic apply(input vec_t v);
        #1;
        rst_i    = v.rst;
        req_i    = v.req;
        tail_i   = v.tail;
        credit_i = v.cr;
        @(negedge clk_i);
        n_cmp++;
        if (ack_o !== v.ack || fwd_o !== (|v.ack) || sel_o !== v.sel ||
            busy_o !== v.busy || credits_o !== v.cred || err_o !== v.err) begin
            n_bad++;
            $display("FAIL %s: got ack=%b fwd=%b sel=%0d busy=%b cred=%0d err=%b, want ack=%b fwd=%b sel=%0d busy=%b cred=%0d err=%b",
                     v.name, ack_o, fwd_o, sel_o, busy_o, credits_o, err_o,
                     v.ack, |v.ack, v.sel, v.busy, v.cred, v.err);
        end
        @(posedge clk_i);
    endtask

    initial begin
        //              name        rst  req       tail      cr    ack       sel   busy  cred  err
        vecs[0]  = '{"reset",     1'b1, 5'b00000, 5'b00000, 1'b0, 5'b00000, 3'd0, 1'b0, 3'd4, 1'b0};
        vecs[1]  = '{"arb_1",     1'b0, 5'b10110, 5'b11111, 1'b0, 5'b00010, 3'd1, 1'b0, 3'd4, 1'b0};
        vecs[2]  = '{"arb_2",     1'b0, 5'b10110, 5'b11111, 1'b1, 5'b00100, 3'd2, 1'b0, 3'd3, 1'b0};
        vecs[3]  = '{"arb_3",     1'b0, 5'b10110, 5'b11111, 1'b1, 5'b10000, 3'd4, 1'b0, 3'd3, 1'b0};
        vecs[4]  = '{"idle_cr",   1'b0, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 3'd3, 1'b0};
        vecs[5]  = '{"pkt3_head", 1'b0, 5'b01000, 5'b00000, 1'b0, 5'b01000, 3'd3, 1'b0, 3'd4, 1'b0};
        vecs[6]  = '{"pkt3_b1",   1'b0, 5'b01001, 5'b00000, 1'b0, 5'b01000, 3'd3, 1'b1, 3'd3, 1'b0};
        vecs[7]  = '{"pkt3_b2cr", 1'b0, 5'b01001, 5'b00000, 1'b1, 5'b01000, 3'd3, 1'b1, 3'd2, 1'b0};
        vecs[8]  = '{"pkt3_tail", 1'b0, 5'b01001, 5'b01000, 1'b0, 5'b01000, 3'd3, 1'b1, 3'd2, 1'b0};
        vecs[9]  = '{"in0_after", 1'b0, 5'b00001, 5'b00001, 1'b1, 5'b00001, 3'd0, 1'b0, 3'd1, 1'b0};
        vecs[10] = '{"refill_1",  1'b0, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 3'd1, 1'b0};
        vecs[11] = '{"refill_2",  1'b0, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 3'd2, 1'b0};
        vecs[12] = '{"refill_3",  1'b0, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 3'd3, 1'b0};
        vecs[13] = '{"overflow",  1'b0, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 3'd4, 1'b0};
        vecs[14] = '{"err_stick", 1'b0, 5'b00000, 5'b00000, 1'b0, 5'b00000, 3'd0, 1'b0, 3'd4, 1'b1};
        vecs[15] = '{"pkt1_f1",   1'b0, 5'b00010, 5'b00000, 1'b0, 5'b00010, 3'd1, 1'b0, 3'd4, 1'b1};
        vecs[16] = '{"pkt1_f2",   1'b0, 5'b00010, 5'b00000, 1'b0, 5'b00010, 3'd1, 1'b1, 3'd3, 1'b1};
        vecs[17] = '{"pkt1_f3",   1'b0, 5'b00010, 5'b00000, 1'b0, 5'b00010, 3'd1, 1'b1, 3'd2, 1'b1};
        vecs[18] = '{"pkt1_f4",   1'b0, 5'b00010, 5'b00000, 1'b0, 5'b00010, 3'd1, 1'b1, 3'd1, 1'b1};
        vecs[19] = '{"no_credit", 1'b0, 5'b00111, 5'b00000, 1'b0, 5'b00000, 3'd1, 1'b1, 3'd0, 1'b1};
        vecs[20] = '{"cr_pulse",  1'b0, 5'b00111, 5'b00000, 1'b1, 5'b00000, 3'd1, 1'b1, 3'd0, 1'b1};
        vecs[21] = '{"pkt1_f5",   1'b0, 5'b00111, 5'b00000, 1'b0, 5'b00010, 3'd1, 1'b1, 3'd1, 1'b1};
        vecs[22] = '{"bubble",    1'b0, 5'b00101, 5'b00000, 1'b1, 5'b00000, 3'd1, 1'b1, 3'd0, 1'b1};
        vecs[23] = '{"pkt1_tail", 1'b0, 5'b00111, 5'b00010, 1'b0, 5'b00010, 3'd1, 1'b1, 3'd1, 1'b1};
        vecs[24] = '{"idle_nocr", 1'b0, 5'b00111, 5'b00111, 1'b0, 5'b00000, 3'd2, 1'b0, 3'd0, 1'b1};
        vecs[25] = '{"idle_crin", 1'b0, 5'b00111, 5'b00111, 1'b1, 5'b00000, 3'd2, 1'b0, 3'd0, 1'b1};
        vecs[26] = '{"idle_go",   1'b0, 5'b00111, 5'b00111, 1'b0, 5'b00100, 3'd2, 1'b0, 3'd1, 1'b1};

        rst_i    = 1'b1;
        req_i    = '0;
        tail_i   = '0;
        credit_i = 1'b0;
        repeat (2) @(posedge clk_i);

        for (int i = 0; i < 27; i++) begin
            apply(vecs[i]);
        end

        // Reset in the middle of a packet from input 2.
        apply('{"r36_rst0",  1'b1, 5'b00000, 5'b00000, 1'b0, 5'b00000, 3'd0, 1'b0, 3'd0, 1'b1});
        apply('{"r36_head",  1'b0, 5'b00100, 5'b00000, 1'b0, 5'b00100, 3'd2, 1'b0, 3'd4, 1'b0});
        apply('{"r36_body",  1'b0, 5'b00101, 5'b00000, 1'b0, 5'b00100, 3'd2, 1'b1, 3'd3, 1'b0});
        apply('{"r36_rst",   1'b1, 5'b00101, 5'b00000, 1'b0, 5'b00000, 3'd2, 1'b1, 3'd2, 1'b0});
        apply('{"r36_after", 1'b0, 5'b00101, 5'b00001, 1'b0, 5'b00001, 3'd0, 1'b0, 3'd4, 1'b0});

        // Round-robin rotation with every input sending single-flit packets.
        apply('{"r37_rst",   1'b1, 5'b00000, 5'b00000, 1'b0, 5'b00000, 3'd0, 1'b0, 3'd3, 1'b0});
        for (int k = 0; k < 10; k++) begin
            vec_t v;
            v = '{$sformatf("rotate_%0d", k), 1'b0, 5'b11111, 5'b11111, 1'b1,
                  5'(1 << (k % 5)), 3'(k % 5), 1'b0, 3'd4, 1'b0};
            apply(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
